// File: rtl/uart_v3.sv
// Full-duplex UART: runtime parity and stop-bit count, majority-vote RX sampling,
// valid/ready handshakes on both sides and a shared, software-loadable clock divider.
module uart_v3 #(
    parameter int CLK_HZ       = 50000000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int DATA_BITS    = 8,
    parameter int DIV_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 is_receiving,
    output logic                 is_transmitting,
    input  logic                 set_clock_div,
    input  logic [DIV_WIDTH-1:0] user_clock_div,
    output logic [DIV_WIDTH-1:0] clock_div
);

    localparam int DEFAULT_DIV = CLK_HZ / (OVERSAMPLE * DEFAULT_BAUD) - 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = 4;
    localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SAMPLE_LO  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] SAMPLE_MID = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] SAMPLE_HI  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    // A divider load aborts both machines exactly like reset does.
    logic abort;
    assign abort = rst | set_clock_div;

    always_ff @(posedge clk) begin
        if (set_clock_div)
            clock_div <= user_clock_div;
        else if (rst)
            clock_div <= DIV_WIDTH'(DEFAULT_DIV);
    end

    tx_state_t            tx_state, tx_next;
    logic [DIV_WIDTH-1:0] tx_div_cnt;
    logic [TW-1:0]        tx_tick_cnt;
    logic [BW-1:0]        tx_bit_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par_en, tx_par_bit, tx_two_stop;
    logic                 tx_accept, tx_tick, tx_bit_done;

    assign tx_accept   = (tx_state == TX_IDLE) && tx_valid;
    assign tx_tick     = (tx_state != TX_IDLE) && (tx_div_cnt == '0);
    assign tx_bit_done = tx_tick && (tx_tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (abort)
            tx_state <= TX_IDLE;
        else
            tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_valid) tx_next = TX_START;
            TX_START:  if (tx_bit_done) tx_next = TX_DATA;
            TX_DATA:   if (tx_bit_done && tx_bit_idx == BIT_LAST)
                           tx_next = tx_par_en ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_done) tx_next = TX_STOP;
            TX_STOP:   if (tx_bit_done && tx_bit_idx == BW'(tx_two_stop)) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx              = 1'b1;
        tx_ready        = 1'b0;
        is_transmitting = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_ready        = 1'b1;
                is_transmitting = 1'b0;
            end
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = tx_shift[0];
            TX_PARITY: tx = tx_par_bit;
            default:   tx = 1'b1;
        endcase
    end

    // Mode and parity are frozen at accept so mid-frame input changes cannot corrupt the frame.
    always_ff @(posedge clk) begin
        if (abort) begin
            tx_div_cnt  <= '0;
            tx_tick_cnt <= '0;
            tx_bit_idx  <= '0;
            tx_shift    <= '0;
            tx_par_en   <= 1'b0;
            tx_par_bit  <= 1'b0;
            tx_two_stop <= 1'b0;
        end else if (tx_accept) begin
            tx_div_cnt  <= clock_div;
            tx_tick_cnt <= '0;
            tx_bit_idx  <= '0;
            tx_shift    <= tx_data;
            tx_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            tx_par_bit  <= (^tx_data) ^ (parity_mode == 2'b10);
            tx_two_stop <= two_stop;
        end else if (tx_state != TX_IDLE) begin
            if (tx_tick) begin
                tx_div_cnt  <= clock_div;
                tx_tick_cnt <= tx_bit_done ? '0 : tx_tick_cnt + TW'(1);
            end else begin
                tx_div_cnt  <= tx_div_cnt - DIV_WIDTH'(1);
            end
            if (tx_bit_done) begin
                if (tx_state == TX_DATA) begin
                    tx_shift   <= tx_shift >> 1;
                    tx_bit_idx <= (tx_bit_idx == BIT_LAST) ? '0 : tx_bit_idx + BW'(1);
                end else if (tx_state == TX_STOP) begin
                    tx_bit_idx <= tx_bit_idx + BW'(1);
                end
            end
        end
    end

    rx_state_t            rx_state, rx_next;
    logic                 rx_meta, rx_sync;
    logic [DIV_WIDTH-1:0] rx_div_cnt;
    logic [TW-1:0]        rx_tick_cnt;
    logic [BW-1:0]        rx_bit_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic [1:0]           rx_votes, rx_vote_sum;
    logic                 rx_par_en, rx_odd, rx_par_bit, rx_par_fail;
    logic                 rx_counting, rx_start, rx_tick, rx_sample_done, rx_bit_done;
    logic                 rx_majority, rx_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_counting    = (rx_state == RX_START) || (rx_state == RX_DATA) ||
                            (rx_state == RX_PARITY) || (rx_state == RX_STOP);
    assign rx_start       = (rx_state == RX_IDLE) && !rx_sync;
    assign rx_tick        = rx_counting && (rx_div_cnt == '0);
    assign rx_sample_done = rx_tick && (rx_tick_cnt == SAMPLE_HI);
    assign rx_bit_done    = rx_tick && (rx_tick_cnt == TICK_LAST);
    assign rx_vote_sum    = rx_votes + {1'b0, rx_sync};
    assign rx_majority    = rx_vote_sum[1];
    assign rx_done        = (rx_state == RX_STOP) && rx_sample_done;
    assign rx_par_fail    = rx_par_en && (rx_par_bit != ((^rx_shift) ^ rx_odd));

    always_ff @(posedge clk) begin
        if (abort)
            rx_state <= RX_IDLE;
        else
            rx_state <= rx_next;
    end

    // A bad stop bit parks in WAIT_HIGH so a held-low break yields a single word.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_sync) rx_next = RX_START;
            RX_START:     if (rx_sample_done && rx_majority) rx_next = RX_IDLE;
                          else if (rx_bit_done) rx_next = RX_DATA;
            RX_DATA:      if (rx_bit_done && rx_bit_idx == BIT_LAST)
                              rx_next = rx_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_bit_done) rx_next = RX_STOP;
            RX_STOP:      if (rx_sample_done) rx_next = rx_majority ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        is_receiving = (rx_state != RX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (abort) begin
            rx_div_cnt  <= '0;
            rx_tick_cnt <= '0;
            rx_bit_idx  <= '0;
            rx_shift    <= '0;
            rx_votes    <= '0;
            rx_par_en   <= 1'b0;
            rx_odd      <= 1'b0;
            rx_par_bit  <= 1'b0;
        end else if (rx_start) begin
            rx_div_cnt  <= clock_div;
            rx_tick_cnt <= '0;
            rx_bit_idx  <= '0;
            rx_votes    <= '0;
            rx_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            rx_odd      <= (parity_mode == 2'b10);
        end else if (rx_counting) begin
            if (rx_tick) begin
                rx_div_cnt  <= clock_div;
                rx_tick_cnt <= rx_bit_done ? '0 : rx_tick_cnt + TW'(1);
            end else begin
                rx_div_cnt  <= rx_div_cnt - DIV_WIDTH'(1);
            end
            if (rx_tick && rx_tick_cnt == SAMPLE_LO)
                rx_votes <= {1'b0, rx_sync};
            else if (rx_tick && rx_tick_cnt == SAMPLE_MID)
                rx_votes <= rx_vote_sum;
            if (rx_sample_done && rx_state == RX_DATA)
                rx_shift <= {rx_majority, rx_shift[DATA_BITS-1:1]};
            if (rx_sample_done && rx_state == RX_PARITY)
                rx_par_bit <= rx_majority;
            if (rx_bit_done && rx_state == RX_DATA)
                rx_bit_idx <= rx_bit_idx + BW'(1);
        end
    end

    // A completing frame overwrites the held word only if that word is consumed in the same cycle.
    always_ff @(posedge clk) begin
        if (abort) begin
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else if (rx_done && (!rx_valid || rx_ready)) begin
            rx_valid      <= 1'b1;
            rx_data       <= rx_shift;
            rx_frame_err  <= !rx_majority;
            rx_parity_err <= rx_par_fail;
            rx_overrun    <= 1'b0;
        end else if (rx_done) begin
            rx_overrun    <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid      <= 1'b0;
            rx_overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_v3.sv
// Bench for uart_v3: TX bit-level checks, RX scoreboard (expected words queued as frames are driven),
// error/overrun/glitch cases and a divider reload during transmission.
`timescale 1ns/1ps
module tb_uart_v3;

    localparam int CLK_HZ       = 50000000;
    localparam int DEFAULT_BAUD = 115200;
    localparam int OS           = 16;
    localparam int EXP_DEFAULT_DIV = CLK_HZ / (OS * DEFAULT_BAUD) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_line;
    logic        tx;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_frame_err;
    logic        rx_parity_err;
    logic        rx_overrun;
    logic        is_receiving;
    logic        is_transmitting;
    logic        set_clock_div;
    logic [15:0] user_clock_div;
    logic [15:0] clock_div;

    logic        rx_drv = 1'b1;
    logic        loopback = 1'b0;
    int          testsRun = 0;
    int          failures = 0;
    int          rxWords = 0;
    logic [9:0]  rxExp[$];

    assign rx_line = loopback ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_v3 #(
        .CLK_HZ(CLK_HZ), .DEFAULT_BAUD(DEFAULT_BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(8), .DIV_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx_line), .tx(tx),
        .parity_mode(parity_mode), .two_stop(two_stop),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun),
        .is_receiving(is_receiving), .is_transmitting(is_transmitting),
        .set_clock_div(set_clock_div), .user_clock_div(user_clock_div), .clock_div(clock_div)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every handshake completion pops the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            logic [9:0] expWord;
            checkOutput("rx_word_expected", 32'(rxExp.size() != 0), 32'd1);
            if (rxExp.size() != 0) begin
                expWord = rxExp.pop_front();
                checkOutput("rx_word", {22'b0, rx_data, rx_frame_err, rx_parity_err}, {22'b0, expWord});
            end
            rxWords++;
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic driveBit(input logic v);
        rx_drv = v;
        repeat (OS) @(negedge clk);
    endtask

    task automatic driveRxFrame(input logic [7:0] data, input logic [1:0] pm, input logic flipPar,
                                input logic stopVal, input logic pushExp);
        logic parEn, wantPar, sentPar;
        parEn   = (pm == 2'b01) || (pm == 2'b10);
        wantPar = (^data) ^ (pm == 2'b10);
        sentPar = wantPar ^ flipPar;
        if (pushExp)
            rxExp.push_back({data, ~stopVal, parEn && (sentPar != wantPar)});
        @(negedge clk);
        parity_mode = pm;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++)
            driveBit(data[i]);
        if (parEn)
            driveBit(sentPar);
        driveBit(stopVal);
    endtask

    // Sends one TX word and checks every bit at mid-bit plus the tx_ready release edge.
    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] pm, input logic ts);
        logic txExp[$];
        logic expBit;
        int   n;
        txExp.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            txExp.push_back(data[i]);
        if (pm == 2'b01) txExp.push_back(^data);
        if (pm == 2'b10) txExp.push_back(~^data);
        txExp.push_back(1'b1);
        if (ts) txExp.push_back(1'b1);
        n = txExp.size();
        @(negedge clk);
        checkOutput("tx_ready_idle", 32'(tx_ready), 32'd1);
        parity_mode = pm;
        two_stop    = ts;
        tx_data     = data;
        tx_valid    = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        for (int cyc = 0; cyc <= n * OS; cyc++) begin
            @(negedge clk);
            if (cyc == 0)
                checkOutput("tx_start_edge", 32'(tx), 32'd0);
            if (cyc % OS == OS / 2) begin
                expBit = txExp.pop_front();
                checkOutput("tx_bit", 32'(tx), 32'(expBit));
            end
            if (cyc == n * OS - 1)
                checkOutput("tx_ready_busy_end", 32'(tx_ready), 32'd0);
            if (cyc == n * OS)
                checkOutput("tx_ready_return", 32'(tx_ready), 32'd1);
        end
    endtask

    initial begin
        int savedWords;
        rst = 1'b1;
        parity_mode = 2'b00;
        two_stop = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        rx_ready = 1'b1;
        set_clock_div = 1'b0;
        user_clock_div = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
        checkOutput("rst_flags", {29'b0, rx_frame_err, rx_parity_err, rx_overrun}, 32'd0);
        checkOutput("rst_busy", {30'b0, is_receiving, is_transmitting}, 32'd0);
        checkOutput("rst_clock_div", 32'(clock_div), 32'(EXP_DEFAULT_DIV));

        @(posedge clk);
        #1 set_clock_div = 1'b1;
        user_clock_div = 16'd0;
        @(posedge clk);
        #1 set_clock_div = 1'b0;
        @(negedge clk);
        checkOutput("div_load_zero", 32'(clock_div), 32'd0);

        applyStimulus(8'hA5, 2'b00, 1'b0);
        applyStimulus(8'h07, 2'b01, 1'b1);
        applyStimulus(8'h07, 2'b10, 1'b0);

        loopback = 1'b1;
        rxExp.push_back({8'h3C, 1'b0, 1'b0});
        applyStimulus(8'h3C, 2'b10, 1'b0);
        repeat (OS) @(negedge clk);
        loopback = 1'b0;

        driveRxFrame(8'h3C, 2'b10, 1'b1, 1'b1, 1'b1);
        repeat (OS) @(negedge clk);

        savedWords = rxWords;
        driveRxFrame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1);
        repeat (40 * OS) @(negedge clk);
        checkOutput("break_wait_high", 32'(is_receiving), 32'd1);
        checkOutput("break_single_word", 32'(rxWords - savedWords), 32'd1);
        rx_drv = 1'b1;
        repeat (2 * OS) @(negedge clk);
        checkOutput("break_released", 32'(is_receiving), 32'd0);
        checkOutput("break_no_retrigger", 32'(rxWords - savedWords), 32'd1);

        @(posedge clk);
        #1 rx_ready = 1'b0;
        driveRxFrame(8'h11, 2'b00, 1'b0, 1'b1, 1'b1);
        driveRxFrame(8'h22, 2'b00, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("ovr_valid_held", 32'(rx_valid), 32'd1);
        checkOutput("ovr_data_held", 32'(rx_data), 32'h11);
        checkOutput("ovr_flag", 32'(rx_overrun), 32'd1);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("consume_valid", 32'(rx_valid), 32'd0);
        checkOutput("consume_overrun", 32'(rx_overrun), 32'd0);

        savedWords = rxWords;
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * OS) @(negedge clk);
        checkOutput("glitch_idle", 32'(is_receiving), 32'd0);
        checkOutput("glitch_no_word", 32'(rxWords - savedWords), 32'd0);
        checkOutput("glitch_no_valid", 32'(rx_valid), 32'd0);

        @(negedge clk);
        parity_mode = 2'b00;
        two_stop = 1'b0;
        tx_data = 8'hF0;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        checkOutput("midtx_busy", 32'(is_transmitting), 32'd1);
        @(posedge clk);
        #1 set_clock_div = 1'b1;
        user_clock_div = 16'd3;
        @(posedge clk);
        #1 set_clock_div = 1'b0;
        @(negedge clk);
        checkOutput("abort_tx_line", 32'(tx), 32'd1);
        checkOutput("abort_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("abort_tx_idle", 32'(is_transmitting), 32'd0);
        checkOutput("abort_clock_div", 32'(clock_div), 32'd3);

        checkOutput("rx_queue_drained", 32'(rxExp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
